scene_scheduler: RTL and testbench
==================================

# scene_scheduler

Frame-rate scene controller that owns the sprite object table and decides, once per video frame, what the graphics accelerator draws next. It advances object positions (player steering, bouncing for the rest), accepts spawn/despawn requests and selects the back-buffer page. It stalls the scene whenever the Clk-domain draw sequencer has not finished the previous list. The draw sequencer reads the table through a combinational read port that is stable for a whole frame.

## Interface
Parameters:
- N_OBJ, 8: object slots; slot 0 is the player.
- PLAYER_SPEED, 2: player pixels per frame per axis.
- PLAYER_X0, 312: player reset X.
- PLAYER_Y0, 232: player reset Y.

Ports:
- frame_clk  in  1  clock, one edge per frame.
- Reset  in  1  reset: synchronous, active-high; clock frame_clk.
- dir  in  4  player direction {up,down,left,right}.
- draw_complete  in  1  previous list fully drawn; level, pre-synchronized to frame_clk.
- spawn_valid  in  1  spawn request, held until ack.
- spawn_img_id  in  3  sprite ROM select.
- spawn_x, spawn_y  in  10  spawn position.
- spawn_dx, spawn_dy  in  4  signed velocity.
- spawn_ack  out  1  spawn accepted.
- spawn_full  out  1  no free slot.
- despawn_valid  in  1  single-frame despawn strobe.
- despawn_idx  in  3  slot to free; slot 0 is ignored.
- rd_idx  in  3  read slot.
- rd_valid  out  1  slot enabled.
- rd_img_id  out  3  slot sprite.
- rd_x, rd_y  out  10  slot position.
- page  out  1  frame buffer the draw sequencer writes next.
- list_seq  out  8  committed-frame counter; a change means a new list.
- dropped  out  8  stalled-frame counter, saturating.

## Operation
- Reset values:
  - slot 0: enabled, img_id 0, (PLAYER_X0, PLAYER_Y0), velocity 0.
  - slots 1..N_OBJ-1: disabled.
  - page 0, list_seq 0, dropped 0, spawn_ack 0, state RUN.
  - spawn_full is combinational: 0 after reset.
- State RUN, on each edge where draw_complete=1 (commit):
  - every enabled slot is moved;
  - page is toggled;
  - list_seq is incremented (wraps 255→0);
  - pending spawn/despawn is applied.
- RUN, on an edge where draw_complete=0: transition to STALL. The table, page and list_seq are held, and dropped is incremented.
- STALL, each edge:
  - draw_complete=1: perform one full commit and return to RUN;
  - otherwise: dropped is incremented (saturates at 255), nothing else changes.
- Motion per axis: next = pos + sign-extended velocity, computed 11-bit signed. The limit is 624 for X and 464 for Y (16-pixel sprites).
- Slots 1..N: when next < 0 or next > limit, the position clamps to the bound and that velocity component is negated.
- Player:
  - velocity is ±PLAYER_SPEED from dir, with opposing bits cancelling;
  - position clamps at the bounds without bounce.
- Spawn:
  - accepted at a commit when spawn_valid=1 and spawn_ack=0;
  - goes into the lowest-index disabled slot;
  - spawn_ack=1 for exactly the next frame.
  - spawn_full = no slot disabled.
  - When full, the request waits, with no ack.
- Despawn: clears the enable of despawn_idx at a commit.
  - A despawn strobe that lands on a non-commit edge is dropped.
  - Despawn is evaluated before spawn, so a freed slot is reusable in the same commit.
- Newly spawned objects are not moved until the following commit.

## Timing
- All state updates happen on the frame_clk edge.
- rd_* are combinational from the registered table, so they are constant between edges.
- list_seq and page change together at the same edge.
- The Clk-domain consumer samples list_seq through a 2-flop synchronizer and compares it to its last value.
- Reset asserted mid-frame: all state is restored at the next edge.

## Structure
- Package scene_pkg holds:
  - obj_t struct {en, img_id[2:0], x[9:0], y[9:0], dx[3:0], dy[3:0]};
  - SCREEN_W=640, SCREEN_H=480, SPRITE_SIZE=16, N_OBJ_MAX=8;
  - state enum {RUN, STALL}.
- Sub-module obj_axis_step: combinational; inputs pos, vel, limit, bounce_en; outputs next_pos, next_vel. It is instantiated twice per slot.
- Free-slot priority encoder and FSM live in the top module.

## Test plan
- Reset, then 3 commits with dir=0001: player X 312→318, Y 232; list_seq=3; page=1.
- Spawn id 1 at (620,100) with dx=+7, dy=0:
  - ack next frame in slot 1;
  - following commit: X clamps to 624 and dx becomes -7;
  - next commit: X=617.
- draw_complete=0 for 4 edges then 1: dropped=4, positions frozen; then one commit, list_seq +1.
- Fill all 7 free slots: spawn_full=1; an 8th spawn_valid gets no ack. Despawn slot 3 with the spawn still pending: that commit reuses slot 3 and acks.
- dir=1100 (up and down): player Y unchanged. Player at Y=1 with dir=1000: Y clamps to 0, no bounce.
- Despawn of index 0 is ignored: slot 0 stays enabled.

Source files
------------

// File: rtl/scene_pkg.sv
// -----------------------------------------------------------------------------
// scene_pkg
// Shared types and constants for the frame-rate scene controller: the sprite
// object record, screen geometry, the per-axis position limits and the
// controller state enum. Also holds a small saturating-increment helper.
// No ports (package).
// -----------------------------------------------------------------------------
package scene_pkg;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int SPRITE_SIZE = 16;
  localparam int N_OBJ_MAX   = 8;

  // Largest top-left coordinate that keeps a whole sprite on screen.
  localparam logic [9:0] X_LIMIT = 10'(SCREEN_W - SPRITE_SIZE);
  localparam logic [9:0] Y_LIMIT = 10'(SCREEN_H - SPRITE_SIZE);

  typedef struct packed {
    logic              en;
    logic [2:0]        img_id;
    logic [9:0]        x;
    logic [9:0]        y;
    logic signed [3:0] dx;
    logic signed [3:0] dy;
  } obj_t;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/obj_axis_step.sv
// -----------------------------------------------------------------------------
// obj_axis_step
// Combinational one-axis motion step for a sprite. Adds the signed velocity to
// the position in 11-bit signed arithmetic, clamps the result to [0, limit]
// and, when bounce_en is set, negates the velocity on a clamp.
// Ports:
//   pos       in  10  current position
//   vel       in  4   signed velocity
//   limit     in  10  largest legal position
//   bounce_en in  1   negate velocity when clamped
//   next_pos  out 10  position after this frame
//   next_vel  out 4   velocity after this frame
// -----------------------------------------------------------------------------
module obj_axis_step (
  input  logic [9:0]        pos,
  input  logic signed [3:0] vel,
  input  logic [9:0]        limit,
  input  logic              bounce_en,
  output logic [9:0]        next_pos,
  output logic signed [3:0] next_vel
);

  logic signed [10:0] w_sum;
  logic signed [10:0] w_limit_s;

  assign w_sum     = $signed({1'b0, pos}) + $signed({{7{vel[3]}}, vel});
  assign w_limit_s = $signed({1'b0, limit});

  // Clamp to the nearest bound on overshoot; a bouncing object reverses the
  // offending velocity component, the player simply stops at the edge.
  always_comb begin
    next_pos = w_sum[9:0];
    next_vel = vel;
    if (w_sum < 11'sd0) begin
      next_pos = 10'd0;
      if (bounce_en) next_vel = -vel;
    end else if (w_sum > w_limit_s) begin
      next_pos = limit;
      if (bounce_en) next_vel = -vel;
    end
  end

endmodule

// File: rtl/scene_scheduler.sv
// -----------------------------------------------------------------------------
// scene_scheduler
// Once-per-frame scene controller. Owns the sprite object table, moves every
// enabled object at each commit (player steered by dir, others bounce), applies
// despawn then spawn requests, toggles the back-buffer page and bumps list_seq.
// When the draw sequencer has not finished (draw_complete=0) the scene is
// frozen and the dropped counter advances instead.
// Ports:
//   frame_clk            in   1   one edge per frame
//   Reset                in   1   synchronous, active-high
//   dir                  in   4   player {up,down,left,right}
//   draw_complete        in   1   previous list drawn (level)
//   spawn_valid          in   1   spawn request, held until ack
//   spawn_img_id         in   3   sprite ROM select
//   spawn_x, spawn_y     in   10  spawn position
//   spawn_dx, spawn_dy   in   4   signed spawn velocity
//   spawn_ack            out  1   spawn accepted (one frame)
//   spawn_full           out  1   no free slot
//   despawn_valid        in   1   despawn strobe
//   despawn_idx          in   3   slot to free (slot 0 ignored)
//   rd_idx               in   3   read slot
//   rd_valid/img_id/x/y  out      combinational read of the table
//   page                 out  1   buffer the draw sequencer writes next
//   list_seq             out  8   committed-frame counter
//   dropped              out  8   stalled-frame counter, saturating
// -----------------------------------------------------------------------------
module scene_scheduler
  import scene_pkg::*;
#(
  parameter int N_OBJ        = 8,
  parameter int PLAYER_SPEED = 2,
  parameter int PLAYER_X0    = 312,
  parameter int PLAYER_Y0    = 232
) (
  input  logic              frame_clk,
  input  logic              Reset,
  input  logic [3:0]        dir,
  input  logic              draw_complete,
  input  logic              spawn_valid,
  input  logic [2:0]        spawn_img_id,
  input  logic [9:0]        spawn_x,
  input  logic [9:0]        spawn_y,
  input  logic signed [3:0] spawn_dx,
  input  logic signed [3:0] spawn_dy,
  output logic              spawn_ack,
  output logic              spawn_full,
  input  logic              despawn_valid,
  input  logic [2:0]        despawn_idx,
  input  logic [2:0]        rd_idx,
  output logic              rd_valid,
  output logic [2:0]        rd_img_id,
  output logic [9:0]        rd_x,
  output logic [9:0]        rd_y,
  output logic              page,
  output logic [7:0]        list_seq,
  output logic [7:0]        dropped
);

  localparam logic [3:0]        N_OBJ_L  = 4'(N_OBJ);
  localparam logic signed [3:0] P_SPEED  = 4'(PLAYER_SPEED);
  localparam obj_t              PLAYER_RESET = '{en: 1'b1, img_id: 3'd0,
                                                 x: 10'(PLAYER_X0), y: 10'(PLAYER_Y0),
                                                 dx: 4'sd0, dy: 4'sd0};

  obj_t   r_obj [N_OBJ];
  obj_t   w_obj_next [N_OBJ];
  state_t r_state, w_state_next;
  logic   r_page;
  logic   [7:0] r_list_seq;
  logic   [7:0] r_dropped;
  logic   r_spawn_ack;

  logic   w_commit;
  logic   w_spawn_accept;
  logic   w_free_found;
  logic   [2:0] w_free_idx;
  logic   w_any_free;

  logic   [9:0]        w_next_x  [N_OBJ];
  logic   [9:0]        w_next_y  [N_OBJ];
  logic   signed [3:0] w_next_dx [N_OBJ];
  logic   signed [3:0] w_next_dy [N_OBJ];

  logic   signed [3:0] w_player_vx;
  logic   signed [3:0] w_player_vy;

  // Opposing direction bits cancel to zero velocity on that axis.
  function automatic logic signed [3:0] axis_vel(input logic neg, input logic pos);
    case ({neg, pos})
      2'b01:   return P_SPEED;
      2'b10:   return -P_SPEED;
      default: return 4'sd0;
    endcase
  endfunction

  assign w_player_vx = axis_vel(dir[1], dir[0]);
  assign w_player_vy = axis_vel(dir[3], dir[2]);
  assign w_commit    = draw_complete;

  for (genvar gi = 0; gi < N_OBJ; gi++) begin : g_slot
    logic signed [3:0] w_vx;
    logic signed [3:0] w_vy;
    logic              w_bounce;

    if (gi == 0) begin : g_player
      assign w_vx     = w_player_vx;
      assign w_vy     = w_player_vy;
      assign w_bounce = 1'b0;
    end else begin : g_npc
      assign w_vx     = r_obj[gi].dx;
      assign w_vy     = r_obj[gi].dy;
      assign w_bounce = 1'b1;
    end

    obj_axis_step u_step_x (
      .pos       (r_obj[gi].x),
      .vel       (w_vx),
      .limit     (X_LIMIT),
      .bounce_en (w_bounce),
      .next_pos  (w_next_x[gi]),
      .next_vel  (w_next_dx[gi])
    );

    obj_axis_step u_step_y (
      .pos       (r_obj[gi].y),
      .vel       (w_vy),
      .limit     (Y_LIMIT),
      .bounce_en (w_bounce),
      .next_pos  (w_next_y[gi]),
      .next_vel  (w_next_dy[gi])
    );
  end

  // Next-state and next-table logic. Both states commit on draw_complete;
  // the state itself only records whether the last edge was a stall.
  // Despawn is applied before the free-slot search so a slot freed this frame
  // can be reused by the spawn in the same commit. Spawned objects are written
  // after the motion step, so they do not move until the following commit.
  always_comb begin
    w_state_next   = r_state;
    w_obj_next     = r_obj;
    w_spawn_accept = 1'b0;
    w_free_found   = 1'b0;
    w_free_idx     = 3'd0;

    case (r_state)
      RUN:     w_state_next = w_commit ? RUN : STALL;
      STALL:   w_state_next = w_commit ? RUN : STALL;
      default: w_state_next = RUN;
    endcase

    if (w_commit) begin
      for (int i = 0; i < N_OBJ; i++) begin
        if (r_obj[i].en) begin
          w_obj_next[i].x  = w_next_x[i];
          w_obj_next[i].y  = w_next_y[i];
          w_obj_next[i].dx = w_next_dx[i];
          w_obj_next[i].dy = w_next_dy[i];
        end
      end

      if (despawn_valid && (despawn_idx != 3'd0) && ({1'b0, despawn_idx} < N_OBJ_L))
        w_obj_next[despawn_idx].en = 1'b0;

      // Descending scan so the lowest-index free slot wins.
      for (int i = N_OBJ - 1; i >= 1; i--) begin
        if (!w_obj_next[i].en) begin
          w_free_found = 1'b1;
          w_free_idx   = 3'(i);
        end
      end

      if (spawn_valid && !r_spawn_ack && w_free_found) begin
        w_spawn_accept         = 1'b1;
        w_obj_next[w_free_idx] = '{en: 1'b1, img_id: spawn_img_id, x: spawn_x, y: spawn_y,
                                   dx: spawn_dx, dy: spawn_dy};
      end
    end
  end

  // Frame-edge register update; reset restores the player and clears the rest.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_state     <= RUN;
      r_page      <= 1'b0;
      r_list_seq  <= 8'd0;
      r_dropped   <= 8'd0;
      r_spawn_ack <= 1'b0;
      for (int i = 0; i < N_OBJ; i++)
        r_obj[i] <= (i == 0) ? PLAYER_RESET : '0;
    end else begin
      r_state     <= w_state_next;
      r_obj       <= w_obj_next;
      r_spawn_ack <= w_spawn_accept;
      if (w_commit) begin
        r_page     <= ~r_page;
        r_list_seq <= r_list_seq + 8'd1;
      end else begin
        r_dropped  <= sat_inc8(r_dropped);
      end
    end
  end

  // Full means no disabled slot among the non-player entries right now.
  always_comb begin
    w_any_free = 1'b0;
    for (int i = 1; i < N_OBJ; i++)
      if (!r_obj[i].en) w_any_free = 1'b1;
  end

  // Read port for the draw sequencer; out-of-range slots read as empty.
  always_comb begin
    rd_valid  = 1'b0;
    rd_img_id = 3'd0;
    rd_x      = 10'd0;
    rd_y      = 10'd0;
    if ({1'b0, rd_idx} < N_OBJ_L) begin
      rd_valid  = r_obj[rd_idx].en;
      rd_img_id = r_obj[rd_idx].img_id;
      rd_x      = r_obj[rd_idx].x;
      rd_y      = r_obj[rd_idx].y;
    end
  end

  assign spawn_full = ~w_any_free;
  assign spawn_ack  = r_spawn_ack;
  assign page       = r_page;
  assign list_seq   = r_list_seq;
  assign dropped    = r_dropped;

endmodule

// File: tb/tb_scene_scheduler.sv
// -----------------------------------------------------------------------------
// tb_scene_scheduler
// Directed, self-checking bench for scene_scheduler. Each task drives one
// scenario and checks hand-computed values of the table read port and the
// frame counters.
// -----------------------------------------------------------------------------
module tb_scene_scheduler;

  logic              frame_clk;
  logic              Reset;
  logic [3:0]        dir;
  logic              draw_complete;
  logic              spawn_valid;
  logic [2:0]        spawn_img_id;
  logic [9:0]        spawn_x, spawn_y;
  logic signed [3:0] spawn_dx, spawn_dy;
  logic              spawn_ack, spawn_full;
  logic              despawn_valid;
  logic [2:0]        despawn_idx;
  logic [2:0]        rd_idx;
  logic              rd_valid;
  logic [2:0]        rd_img_id;
  logic [9:0]        rd_x, rd_y;
  logic              page;
  logic [7:0]        list_seq, dropped;

  int compared   = 0;
  int mismatched = 0;

  scene_scheduler dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .dir           (dir),
    .draw_complete (draw_complete),
    .spawn_valid   (spawn_valid),
    .spawn_img_id  (spawn_img_id),
    .spawn_x       (spawn_x),
    .spawn_y       (spawn_y),
    .spawn_dx      (spawn_dx),
    .spawn_dy      (spawn_dy),
    .spawn_ack     (spawn_ack),
    .spawn_full    (spawn_full),
    .despawn_valid (despawn_valid),
    .despawn_idx   (despawn_idx),
    .rd_idx        (rd_idx),
    .rd_valid      (rd_valid),
    .rd_img_id     (rd_img_id),
    .rd_x          (rd_x),
    .rd_y          (rd_y),
    .page          (page),
    .list_seq      (list_seq),
    .dropped       (dropped)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  // One frame edge, then settle away from the edge before anything is sampled.
  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic select(input logic [2:0] idx);
    rd_idx = idx;
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
    select(3'd0);
    compared++; if (rd_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_p_valid: got %0b expected 1", rd_valid); end
    compared++; if (rd_x !== 10'd312) begin mismatched++; $display("[TB] FAIL reset_p_x: got %0d expected 312", rd_x); end
    compared++; if (rd_y !== 10'd232) begin mismatched++; $display("[TB] FAIL reset_p_y: got %0d expected 232", rd_y); end
    compared++; if (rd_img_id !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_p_img: got %0d expected 0", rd_img_id); end
    select(3'd1);
    compared++; if (rd_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_s1_valid: got %0b expected 0", rd_valid); end
    compared++; if (page !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_page: got %0b expected 0", page); end
    compared++; if (list_seq !== 8'd0) begin mismatched++; $display("[TB] FAIL reset_seq: got %0d expected 0", list_seq); end
    compared++; if (dropped !== 8'd0) begin mismatched++; $display("[TB] FAIL reset_dropped: got %0d expected 0", dropped); end
    compared++; if (spawn_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ack: got %0b expected 0", spawn_ack); end
    compared++; if (spawn_full !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_full: got %0b expected 0", spawn_full); end
  endtask

  task automatic test_player_move();
    dir           = 4'b0001;
    draw_complete = 1'b1;
    repeat (3) step();
    select(3'd0);
    compared++; if (rd_x !== 10'd318) begin mismatched++; $display("[TB] FAIL move_x: got %0d expected 318", rd_x); end
    compared++; if (rd_y !== 10'd232) begin mismatched++; $display("[TB] FAIL move_y: got %0d expected 232", rd_y); end
    compared++; if (list_seq !== 8'd3) begin mismatched++; $display("[TB] FAIL move_seq: got %0d expected 3", list_seq); end
    compared++; if (page !== 1'b1) begin mismatched++; $display("[TB] FAIL move_page: got %0b expected 1", page); end
    dir = 4'b0000;
  endtask

  task automatic test_spawn_bounce();
    spawn_valid  = 1'b1;
    spawn_img_id = 3'd1;
    spawn_x      = 10'd620;
    spawn_y      = 10'd100;
    spawn_dx     = 4'sd7;
    spawn_dy     = 4'sd0;
    step();
    select(3'd1);
    compared++; if (spawn_ack !== 1'b1) begin mismatched++; $display("[TB] FAIL spawn_ack: got %0b expected 1", spawn_ack); end
    compared++; if (rd_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL spawn_s1_valid: got %0b expected 1", rd_valid); end
    compared++; if (rd_img_id !== 3'd1) begin mismatched++; $display("[TB] FAIL spawn_s1_img: got %0d expected 1", rd_img_id); end
    compared++; if (rd_x !== 10'd620) begin mismatched++; $display("[TB] FAIL spawn_s1_x: got %0d expected 620", rd_x); end
    spawn_valid = 1'b0;
    step();
    compared++; if (spawn_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL spawn_ack_drop: got %0b expected 0", spawn_ack); end
    compared++; if (rd_x !== 10'd624) begin mismatched++; $display("[TB] FAIL bounce_clamp_x: got %0d expected 624", rd_x); end
    step();
    compared++; if (rd_x !== 10'd617) begin mismatched++; $display("[TB] FAIL bounce_back_x: got %0d expected 617", rd_x); end
    compared++; if (rd_y !== 10'd100) begin mismatched++; $display("[TB] FAIL bounce_y: got %0d expected 100", rd_y); end
    compared++; if (list_seq !== 8'd6) begin mismatched++; $display("[TB] FAIL bounce_seq: got %0d expected 6", list_seq); end
  endtask

  task automatic test_stall();
    draw_complete = 1'b0;
    repeat (4) step();
    compared++; if (dropped !== 8'd4) begin mismatched++; $display("[TB] FAIL stall_dropped: got %0d expected 4", dropped); end
    compared++; if (list_seq !== 8'd6) begin mismatched++; $display("[TB] FAIL stall_seq: got %0d expected 6", list_seq); end
    compared++; if (page !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_page: got %0b expected 0", page); end
    select(3'd1);
    compared++; if (rd_x !== 10'd617) begin mismatched++; $display("[TB] FAIL stall_s1_x: got %0d expected 617", rd_x); end
    draw_complete = 1'b1;
    step();
    compared++; if (list_seq !== 8'd7) begin mismatched++; $display("[TB] FAIL resume_seq: got %0d expected 7", list_seq); end
    compared++; if (page !== 1'b1) begin mismatched++; $display("[TB] FAIL resume_page: got %0b expected 1", page); end
    compared++; if (rd_x !== 10'd610) begin mismatched++; $display("[TB] FAIL resume_s1_x: got %0d expected 610", rd_x); end
    compared++; if (dropped !== 8'd4) begin mismatched++; $display("[TB] FAIL resume_dropped: got %0d expected 4", dropped); end
  endtask

  task automatic test_fill_and_reuse();
    for (int k = 0; k < 6; k++) begin
      spawn_valid  = 1'b1;
      spawn_img_id = 3'(k + 2);
      spawn_x      = 10'(100 + 10 * k);
      spawn_y      = 10'd50;
      spawn_dx     = 4'sd0;
      spawn_dy     = 4'sd0;
      step();
      select(3'(k + 2));
      compared++; if (spawn_ack !== 1'b1) begin mismatched++; $display("[TB] FAIL fill_ack[%0d]: got %0b expected 1", k, spawn_ack); end
      compared++; if (rd_valid !== 1'b1 || rd_x !== 10'(100 + 10 * k)) begin mismatched++; $display("[TB] FAIL fill_slot[%0d]: got valid %0b x %0d expected valid 1 x %0d", k, rd_valid, rd_x, 100 + 10 * k); end
      spawn_valid = 1'b0;
      step();
    end
    compared++; if (spawn_full !== 1'b1) begin mismatched++; $display("[TB] FAIL full_flag: got %0b expected 1", spawn_full); end
    spawn_valid  = 1'b1;
    spawn_img_id = 3'd5;
    spawn_x      = 10'd200;
    spawn_y      = 10'd300;
    step();
    compared++; if (spawn_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL full_no_ack1: got %0b expected 0", spawn_ack); end
    step();
    compared++; if (spawn_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL full_no_ack2: got %0b expected 0", spawn_ack); end
    despawn_valid = 1'b1;
    despawn_idx   = 3'd3;
    step();
    despawn_valid = 1'b0;
    select(3'd3);
    compared++; if (spawn_ack !== 1'b1) begin mismatched++; $display("[TB] FAIL reuse_ack: got %0b expected 1", spawn_ack); end
    compared++; if (rd_valid !== 1'b1 || rd_img_id !== 3'd5) begin mismatched++; $display("[TB] FAIL reuse_slot3: got valid %0b img %0d expected valid 1 img 5", rd_valid, rd_img_id); end
    compared++; if (rd_x !== 10'd200 || rd_y !== 10'd300) begin mismatched++; $display("[TB] FAIL reuse_pos: got (%0d,%0d) expected (200,300)", rd_x, rd_y); end
    spawn_valid = 1'b0;
    step();
    compared++; if (spawn_full !== 1'b1) begin mismatched++; $display("[TB] FAIL reuse_full: got %0b expected 1", spawn_full); end
  endtask

  task automatic test_player_clamp();
    select(3'd0);
    dir = 4'b1100;
    step();
    compared++; if (rd_y !== 10'd232 || rd_x !== 10'd318) begin mismatched++; $display("[TB] FAIL cancel_pos: got (%0d,%0d) expected (318,232)", rd_x, rd_y); end
    dir = 4'b1000;
    repeat (116) step();
    compared++; if (rd_y !== 10'd0) begin mismatched++; $display("[TB] FAIL up_to_top: got %0d expected 0", rd_y); end
    step();
    compared++; if (rd_y !== 10'd0) begin mismatched++; $display("[TB] FAIL top_clamp: got %0d expected 0", rd_y); end
    dir = 4'b0100;
    step();
    compared++; if (rd_y !== 10'd2) begin mismatched++; $display("[TB] FAIL no_bounce_down: got %0d expected 2", rd_y); end
    dir = 4'b0000;
  endtask

  task automatic test_despawn_rules();
    despawn_valid = 1'b1;
    despawn_idx   = 3'd0;
    step();
    despawn_valid = 1'b0;
    select(3'd0);
    compared++; if (rd_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL despawn0_ignored: got %0b expected 1", rd_valid); end
    draw_complete = 1'b0;
    despawn_valid = 1'b1;
    despawn_idx   = 3'd2;
    step();
    despawn_valid = 1'b0;
    draw_complete = 1'b1;
    step();
    select(3'd2);
    compared++; if (rd_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL stall_despawn_dropped: got %0b expected 1", rd_valid); end
    compared++; if (dropped !== 8'd5) begin mismatched++; $display("[TB] FAIL dropped_after_stall: got %0d expected 5", dropped); end
  endtask

  task automatic test_dropped_saturation();
    draw_complete = 1'b0;
    repeat (260) step();
    compared++; if (dropped !== 8'd255) begin mismatched++; $display("[TB] FAIL dropped_sat: got %0d expected 255", dropped); end
    draw_complete = 1'b1;
    step();
    compared++; if (dropped !== 8'd255) begin mismatched++; $display("[TB] FAIL dropped_hold: got %0d expected 255", dropped); end
  endtask

  task automatic test_mid_run_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    select(3'd0);
    compared++; if (rd_x !== 10'd312 || rd_y !== 10'd232) begin mismatched++; $display("[TB] FAIL rerst_player: got (%0d,%0d) expected (312,232)", rd_x, rd_y); end
    select(3'd1);
    compared++; if (rd_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rerst_s1: got %0b expected 0", rd_valid); end
    compared++; if (list_seq !== 8'd0 || dropped !== 8'd0) begin mismatched++; $display("[TB] FAIL rerst_counters: got seq %0d dropped %0d expected 0 0", list_seq, dropped); end
  endtask

  initial begin
    Reset         = 1'b0;
    dir           = 4'b0000;
    draw_complete = 1'b0;
    spawn_valid   = 1'b0;
    spawn_img_id  = 3'd0;
    spawn_x       = 10'd0;
    spawn_y       = 10'd0;
    spawn_dx      = 4'sd0;
    spawn_dy      = 4'sd0;
    despawn_valid = 1'b0;
    despawn_idx   = 3'd0;
    rd_idx        = 3'd0;

    test_reset();
    test_player_move();
    test_spawn_bounce();
    test_stall();
    test_fill_and_reuse();
    test_player_clamp();
    test_despawn_rules();
    test_dropped_saturation();
    test_mid_run_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
